// File: rtl/sfifo_lvl_if.sv
// Handshake bundle between a producer/consumer (master) and the sfifo_lvl buffer (slave).
// Signal names keep the buffer's own i_/o_ view so both sides read the same way.
interface sfifo_lvl_if #(
  parameter int DW = 8,
  parameter int LW = 7
);
  logic          i_flush;
  logic          i_wr_en;
  logic [DW-1:0] i_wr_data;
  logic          o_full;
  logic          o_afull;
  logic          i_rd;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_empty;
  logic          o_aempty;
  logic [LW-1:0] o_level;
  logic          o_overflow;
  logic          o_underflow;

  modport master (
    output i_flush, i_wr_en, i_wr_data, i_rd,
    input  o_full, o_afull, o_rd_data, o_rd_valid, o_empty, o_aempty,
           o_level, o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_wr_en, i_wr_data, i_rd,
    output o_full, o_afull, o_rd_data, o_rd_valid, o_empty, o_aempty,
           o_level, o_overflow, o_underflow
  );
endinterface

// File: rtl/sfifo_lvl.sv
// Single-clock circular-buffer FIFO with fill level, almost-full/empty thresholds,
// synchronous flush, sticky overflow/underflow and FWFT or registered read modes.
module sfifo_lvl #(
  parameter int FW        = 64,
  parameter int DW        = 8,
  parameter int FWFT      = 1,
  parameter int AFULL_TH  = FW - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  sfifo_lvl_if.slave  bus
);
  localparam int AW = $clog2(FW);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  logic          overflow;
  logic          underflow;
  logic [DW-1:0] mem [FW];

  // Status depends on the pointer registers only; the extra wrap bit
  // distinguishes full from empty when the indices coincide.
  assign level  = wr_ptr - rd_ptr;
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign full   = (level == PW'(FW));
  assign empty  = (level == '0);

  // Each side is judged on pre-edge state; flush overrides both requests.
  assign wr_acc = bus.i_wr_en & ~full  & ~bus.i_flush;
  assign rd_acc = bus.i_rd    & ~empty & ~bus.i_flush;

  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_afull     = (level >= PW'(AFULL_TH));
  assign bus.o_aempty    = (level <= PW'(AEMPTY_TH));
  assign bus.o_level     = level;
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      if (bus.i_wr_en && full)  overflow  <= 1'b1;
      if (bus.i_rd    && empty) underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM primitives;
  // stale contents are never visible because the pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_idx] <= bus.i_wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented asynchronously (distributed RAM read).
      assign bus.o_rd_data  = mem[rd_idx];
      assign bus.o_rd_valid = ~empty;
    end else begin : g_reg
      logic [DW-1:0] rd_data_q;
      logic          rd_valid_q;

      // Synchronous read port with a one-cycle valid strobe per accepted pop.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_idx];
        end
      end

      assign bus.o_rd_data  = rd_data_q;
      assign bus.o_rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sfifo_lvl.sv
// Drives an FWFT and a registered-read sfifo_lvl (FW=8) with identical traffic and
// compares both against a queue-based model of the FIFO rules.
module tb_sfifo_lvl;
  localparam int FW = 8;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int AF = 4;
  localparam int AE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfifo_lvl_if #(.DW(DW), .LW(LW)) bf ();
  sfifo_lvl_if #(.DW(DW), .LW(LW)) br ();

  sfifo_lvl #(.FW(FW), .DW(DW), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut_f (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bf.slave));
  sfifo_lvl #(.FW(FW), .DW(DW), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut_r (
    .i_clk(clk), .i_reset_n(rst_n), .bus(br.slave));

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf, m_unf, m_vr;
  logic [7:0] m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_vr = 1'b0; m_last = 8'h00;
  endtask

  task automatic model_step(input logic fl, input logic wr, input logic [7:0] wd, input logic rd);
    int  n;
    logic wa, ra;
    n = q.size();
    if (fl) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_vr = 1'b0;
    end else begin
      wa = wr && (n != FW);
      ra = rd && (n != 0);
      if (wr && n == FW) m_ovf = 1'b1;
      if (rd && n == 0)  m_unf = 1'b1;
      if (ra) begin m_last = q.pop_front(); m_vr = 1'b1; end
      else m_vr = 1'b0;
      if (wa) q.push_back(wd);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, "_lvl_f"},   32'(bf.o_level),     32'(n));
    chk({tag, "_lvl_r"},   32'(br.o_level),     32'(n));
    chk({tag, "_full"},    32'(bf.o_full),      32'(n == FW));
    chk({tag, "_empty"},   32'(bf.o_empty),     32'(n == 0));
    chk({tag, "_afull"},   32'(bf.o_afull),     32'(n >= AF));
    chk({tag, "_aempty"},  32'(bf.o_aempty),    32'(n <= AE));
    chk({tag, "_ovf_f"},   32'(bf.o_overflow),  32'(m_ovf));
    chk({tag, "_unf_f"},   32'(bf.o_underflow), 32'(m_unf));
    chk({tag, "_ovf_r"},   32'(br.o_overflow),  32'(m_ovf));
    chk({tag, "_unf_r"},   32'(br.o_underflow), 32'(m_unf));
    chk({tag, "_vld_f"},   32'(bf.o_rd_valid),  32'(n != 0));
    if (n != 0) chk({tag, "_dat_f"}, 32'(bf.o_rd_data), 32'(q[0]));
    chk({tag, "_vld_r"},   32'(br.o_rd_valid),  32'(m_vr));
    chk({tag, "_dat_r"},   32'(br.o_rd_data),   32'(m_last));
  endtask

  task automatic drive(input logic fl, input logic wr, input logic [7:0] wd, input logic rd);
    @(negedge clk);
    bf.i_flush = fl; bf.i_wr_en = wr; bf.i_wr_data = wd; bf.i_rd = rd;
    br.i_flush = fl; br.i_wr_en = wr; br.i_wr_data = wd; br.i_rd = rd;
    @(posedge clk);
    model_step(fl, wr, wd, rd);
    #1 check_all("step");
    @(negedge clk);
    bf.i_flush = 1'b0; bf.i_wr_en = 1'b0; bf.i_rd = 1'b0;
    br.i_flush = 1'b0; br.i_wr_en = 1'b0; br.i_rd = 1'b0;
  endtask

  initial begin
    int c;
    bf.i_flush = 1'b0; bf.i_wr_en = 1'b0; bf.i_wr_data = '0; bf.i_rd = 1'b0;
    br.i_flush = 1'b0; br.i_wr_en = 1'b0; br.i_wr_data = '0; br.i_rd = 1'b0;
    model_reset();

    // Reset state
    #12 check_all("rst");
    chk("rst_dat_r", 32'(br.o_rd_data), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
    chk("t1_level", 32'(bf.o_level), 32'd8);
    chk("t1_full",  32'(bf.o_full),  32'd1);
    chk("t1_afull", 32'(bf.o_afull), 32'd1);
    drive(1'b0, 1'b1, 8'h19, 1'b0);
    chk("t1_ovf",   32'(bf.o_overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_head", 32'(bf.o_rd_data), 32'(8'h11 + i));
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      chk("t1_rdat", 32'(br.o_rd_data), 32'(8'h11 + i));
    end
    chk("t1_empty", 32'(bf.o_empty), 32'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    // Wrap: 5 in / 5 out, four rounds
    c = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, 8'(c), 1'b0); c++; end
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("t2_ovf", 32'(bf.o_overflow),  32'd0);
    chk("t2_unf", 32'(bf.o_underflow), 32'd0);

    // Simultaneous wr+rd at full, then at empty
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    drive(1'b0, 1'b1, 8'hEE, 1'b1);
    chk("t3_level7", 32'(bf.o_level),    32'd7);
    chk("t3_ovf",    32'(bf.o_overflow), 32'd1);
    chk("t3_pop",    32'(br.o_rd_data),  32'h20);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b1, 8'hA5, 1'b1);
    chk("t3_level1", 32'(bf.o_level),     32'd1);
    chk("t3_unf",    32'(bf.o_underflow), 32'd1);
    chk("t3_vld_r",  32'(br.o_rd_valid),  32'd0);
    chk("t3_head",   32'(bf.o_rd_data),   32'hA5);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_a5",     32'(br.o_rd_data),   32'hA5);

    // Registered read timing
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h3C, 1'b0);
    drive(1'b0, 1'b1, 8'hC3, 1'b0);
    chk("t4_vld_pre", 32'(br.o_rd_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_vld1", 32'(br.o_rd_valid), 32'd1);
    chk("t4_dat1", 32'(br.o_rd_data),  32'h3C);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_vld0", 32'(br.o_rd_valid), 32'd0);
    chk("t4_hold", 32'(br.o_rd_data),  32'h3C);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h3C, 1'b0);
    drive(1'b0, 1'b1, 8'hC3, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_b2b_a", 32'(br.o_rd_data), 32'h3C);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_b2b_b", 32'(br.o_rd_data), 32'hC3);
    chk("t4_b2b_v", 32'(br.o_rd_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_end_v", 32'(br.o_rd_valid), 32'd0);

    // Flush beats a concurrent write and clears the sticky flags
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_pre_lvl", 32'(bf.o_level),    32'd5);
    chk("t5_pre_ovf", 32'(bf.o_overflow), 32'd1);
    drive(1'b1, 1'b1, 8'h99, 1'b0);
    chk("t5_lvl",   32'(bf.o_level),    32'd0);
    chk("t5_empty", 32'(bf.o_empty),    32'd1);
    chk("t5_ovf",   32'(bf.o_overflow), 32'd0);
    drive(1'b0, 1'b1, 8'h77, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_77", 32'(br.o_rd_data), 32'h77);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b1, 8'h60, 1'b0);
    chk("t6_pre", 32'(bf.o_level), 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("arst");
    chk("t6_lvl",  32'(br.o_level),   32'd0);
    chk("t6_dat",  32'(br.o_rd_data), 32'h0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_post", 32'(br.o_rd_data), 32'h5A);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(1'(($urandom % 50) == 0), 1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
